// File: rtl/sin_pwm_pkg.sv
// Shared types and default constants for the sine-driven PWM modulator.
package sin_pwm_pkg;

  localparam int unsigned CNT_W_DEFAULT    = 8;
  localparam int unsigned DEADTIME_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sin_pwm_deadtime.sv
// Complementary output generator with dead-time insertion.
// Each output rises only after the raw PWM has been stable for DEADTIME cycles,
// so both outputs are low for DEADTIME cycles after every raw edge.
module sin_pwm_deadtime
  import sin_pwm_pkg::*;
#(
  parameter int unsigned DEADTIME = DEADTIME_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic pwm_in,
  output logic pwm_p,
  output logic pwm_n
);

  localparam int unsigned AW = $clog2(DEADTIME + 2);
  localparam logic [AW-1:0] DT = AW'(DEADTIME);

  logic          prev;
  logic [AW-1:0] age;
  logic [AW-1:0] age_now;
  logic          settled;

  // Age of the current raw level; restarts at zero on the cycle the level changes
  always_comb begin
    age_now = (pwm_in != prev) ? '0 : age;
    settled = (age_now >= DT);
  end

  // Track the raw level and drive gated complementary outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= 1'b0;
      age   <= '0;
      pwm_p <= 1'b0;
      pwm_n <= 1'b0;
    end else begin
      prev  <= pwm_in;
      age   <= settled ? DT : age_now + 1'b1;
      pwm_p <= en && pwm_in && settled;
      pwm_n <= en && !pwm_in && settled;
    end
  end

endmodule

// File: rtl/sin_pwm_modulator.sv
// Sine-sample driven PWM modulator with a one-deep sample buffer.
// Optional feature: define SIN_PWM_DEADTIME_EN to add pwm_n_out with dead-time.
module sin_pwm_modulator
  import sin_pwm_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEFAULT,
  parameter int unsigned DEADTIME = DEADTIME_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic signed [30:0] SinValue_in,
  input  logic               sample_valid,
  output logic               sample_ready,
  output logic               pwm_out,
  output logic               period_start,
  output logic               overflow
`ifdef SIN_PWM_DEADTIME_EN
  ,
  output logic               pwm_n_out
`endif
);

  localparam logic [CNT_W-1:0] DUTY_MID = {1'b1, {(CNT_W-1){1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] duty_active;
  logic [CNT_W-1:0] duty_pending;
  logic [CNT_W-1:0] duty_in;
  logic             pending_valid;
  logic             running;
  logic             wrap;
  logic             accept;
  logic             pwm_raw;
  logic             unused_bits;

  // Offset-binary duty: top CNT_W bits of the sample with the sign inverted
  assign duty_in      = {~SinValue_in[30], SinValue_in[29 -: CNT_W-1]};
  assign unused_bits  = ^{SinValue_in[30-CNT_W:0], DEADTIME[0]};

  assign running      = (state != ST_IDLE);
  assign wrap         = running && (cnt == '1);
  assign sample_ready = !pending_valid;
  assign accept       = sample_valid && !pending_valid;

`ifdef SIN_PWM_DEADTIME_EN
  logic run_q;
`endif

  // Period FSM, counter and registered PWM / period-start outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      pwm_raw      <= 1'b0;
      period_start <= 1'b0;
`ifdef SIN_PWM_DEADTIME_EN
      run_q        <= 1'b0;
`endif
    end else begin
      pwm_raw      <= running && (cnt < duty_active);
      period_start <= running && (cnt == '0);
`ifdef SIN_PWM_DEADTIME_EN
      run_q        <= running;
`endif
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (ena) state <= ST_RUN;
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (!ena) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          cnt <= cnt + 1'b1;
          if (ena)       state <= ST_RUN;
          else if (wrap) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Sample buffer: pending duty moves to active at wrap; a sample accepted
  // in the wrap cycle lands in the (just emptied) pending slot
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_valid <= 1'b0;
      duty_pending  <= '0;
      duty_active   <= DUTY_MID;
      overflow      <= 1'b0;
    end else begin
      if (wrap && pending_valid) duty_active <= duty_pending;
      if (accept) begin
        duty_pending  <= duty_in;
        pending_valid <= 1'b1;
      end else if (wrap) begin
        pending_valid <= 1'b0;
      end
      if (sample_valid && pending_valid) overflow <= 1'b1;
    end
  end

`ifdef SIN_PWM_DEADTIME_EN
  sin_pwm_deadtime #(
    .DEADTIME (DEADTIME)
  ) u_deadtime (
    .clk    (clk),
    .rst    (rst),
    .en     (run_q),
    .pwm_in (pwm_raw),
    .pwm_p  (pwm_out),
    .pwm_n  (pwm_n_out)
  );
`else
  assign pwm_out = pwm_raw;
`endif

endmodule

// File: tb/tb_sin_pwm_modulator.sv
// Directed bench for sin_pwm_modulator (CNT_W=8, DEADTIME=4).
module tb_sin_pwm_modulator;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned DEADTIME = 4;
  localparam int          PERIOD   = 256;

  logic               clk = 1'b0;
  logic               rst;
  logic               ena;
  logic signed [30:0] SinValue_in;
  logic               sample_valid;
  logic               sample_ready;
  logic               pwm_out;
  logic               period_start;
  logic               overflow;
`ifdef SIN_PWM_DEADTIME_EN
  logic               pwm_n_out;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sin_pwm_modulator #(
    .CNT_W    (CNT_W),
    .DEADTIME (DEADTIME)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .SinValue_in  (SinValue_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .overflow     (overflow)
`ifdef SIN_PWM_DEADTIME_EN
    ,
    .pwm_n_out    (pwm_n_out)
`endif
  );

  typedef struct {
    logic signed [30:0] sin;
    int                 exp_hi;
    string              name;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Bounded wait for the next period_start pulse, sampled on the falling edge
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (period_start) ok = 1'b1;
    end
    if (!ok) check("period_start timeout", 0, 1);
  endtask

  // Count pwm_out highs over one period; optionally present a sample at index send_at
  task automatic run_period(input int send_at, input logic signed [30:0] val, output int hi);
    bit ok;
    hi = 0;
    wait_start(ok);
    if (ok) begin
      for (int j = 0; j < PERIOD; j++) begin
        if (j > 0) @(negedge clk);
        sample_valid = (j == send_at);
        SinValue_in  = val;
        hi += int'(pwm_out);
      end
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vec[7];
    int   hi;
    int   cnt_a;
    int   cnt_b;
    bit   ok;

    vec[0] = '{31'sh4000_0000,   0, "duty min (-2^30)"};
    vec[1] = '{31'sh3FFF_FFFF, 255, "duty max (2^30-1)"};
    vec[2] = '{31'sh2000_0000, 192, "duty 2^29"};
    vec[3] = '{31'sh0080_0000, 129, "duty +1 lsb"};
    vec[4] = '{31'sh7F80_0000, 127, "duty -1 lsb"};
    vec[5] = '{31'sh0000_0000, 128, "duty zero sample"};
    vec[6] = '{31'sh6000_0000,  64, "duty -2^29"};

    rst          = 1'b1;
    ena          = 1'b0;
    sample_valid = 1'b0;
    SinValue_in  = '0;
    repeat (3) @(negedge clk);
    check("reset pwm_out", int'(pwm_out), 0);
    check("reset period_start", int'(period_start), 0);
    check("reset overflow", int'(overflow), 0);
    check("reset sample_ready", int'(sample_ready), 1);
`ifdef SIN_PWM_DEADTIME_EN
    check("reset pwm_n_out", int'(pwm_n_out), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

`ifdef SIN_PWM_DEADTIME_EN
    // Reset duty 128: steady-state window of one period
    ena = 1'b1;
    wait_start(ok);
    repeat (2 * PERIOD) @(negedge clk);
    begin
      int np, nn, both, ovl, run, maxrun;
      np = 0; nn = 0; both = 0; ovl = 0; run = 0; maxrun = 0;
      for (int j = 0; j < PERIOD; j++) begin
        @(negedge clk);
        np += int'(pwm_out);
        nn += int'(pwm_n_out);
        if (pwm_out && pwm_n_out) ovl++;
        if (!pwm_out && !pwm_n_out) begin
          both++;
          run++;
          if (run > maxrun) maxrun = run;
        end else begin
          run = 0;
        end
      end
      check("deadtime pwm_out high", np, 124);
      check("deadtime pwm_n_out high", nn, 124);
      check("deadtime both-low cycles", both, 8);
      check("deadtime overlap", ovl, 0);
      check("deadtime gap length", maxrun, 4);
    end
    ena = 1'b0;
`else
    // Sample accepted while idle
    SinValue_in  = '0;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("ready low after idle accept", int'(sample_ready), 0);
    check("idle pwm_out", int'(pwm_out), 0);

    ena = 1'b1;
    run_period(-1, '0, hi);
    check("first period reset duty", hi, 128);
    run_period(0, vec[0].sin, hi);
    check("second period sample 0", hi, 128);
    for (int i = 0; i < 7; i++) begin
      if (i + 1 < 7) run_period(0, vec[i + 1].sin, hi);
      else           run_period(-1, '0, hi);
      check(vec[i].name, hi, vec[i].exp_hi);
    end
    run_period(-1, '0, hi);
    check("duty held without sample", hi, 64);
    check("no overflow after table", int'(overflow), 0);

    // Sample presented in the wrap cycle stays pending one more period
    run_period(254, 31'sh2000_0000, hi);
    check("wrap-accept period", hi, 64);
    check("ready low after wrap accept", int'(sample_ready), 0);
    run_period(-1, '0, hi);
    check("period after wrap accept", hi, 64);
    run_period(-1, '0, hi);
    check("wrap-accepted duty", hi, 192);

    // Two samples in one period: second dropped, overflow set
    wait_start(ok);
    hi = 0;
    if (ok) begin
      for (int j = 0; j < PERIOD; j++) begin
        if (j > 0) @(negedge clk);
        sample_valid = (j == 0) || (j == 5);
        SinValue_in  = (j < 5) ? 31'sh6000_0000 : 31'sh3FFF_FFFF;
        hi += int'(pwm_out);
        if (j == 1) begin
          check("ready low after first sample", int'(sample_ready), 0);
          check("overflow clear before second", int'(overflow), 0);
        end
        if (j == 6) check("overflow set by second sample", int'(overflow), 1);
      end
    end
    sample_valid = 1'b0;
    check("overflow period duty", hi, 192);
    run_period(-1, '0, hi);
    check("duty from first sample", hi, 64);
    run_period(-1, '0, hi);
    check("second sample dropped", hi, 64);
    check("overflow sticky", int'(overflow), 1);

    // ena dropped at cnt=100: period completes, then idle
    wait_start(ok);
    hi = 0;
    if (ok) begin
      for (int j = 0; j < PERIOD; j++) begin
        if (j > 0) @(negedge clk);
        if (j == 99) ena = 1'b0;
        hi += int'(pwm_out);
      end
    end
    check("drain period duty", hi, 64);
    cnt_a = 0;
    cnt_b = 0;
    repeat (300) begin
      @(negedge clk);
      cnt_a += int'(period_start);
      cnt_b += int'(pwm_out);
    end
    check("no period_start after drain", cnt_a, 0);
    check("pwm_out low after drain", cnt_b, 0);

    // rst pulsed at cnt=50 with a sample pending
    ena = 1'b1;
    wait_start(ok);
    if (ok) begin
      for (int j = 1; j < 50; j++) begin
        @(negedge clk);
        sample_valid = (j == 10);
        SinValue_in  = 31'sh2000_0000;
        if (j == 20) check("ready low before reset", int'(sample_ready), 0);
        if (j == 45) check("pwm high before reset", int'(pwm_out), 1);
      end
    end
    rst = 1'b1;
    ena = 1'b0;
    @(negedge clk);
    check("mid-period reset pwm_out", int'(pwm_out), 0);
    check("mid-period reset overflow", int'(overflow), 0);
    check("mid-period reset sample_ready", int'(sample_ready), 1);
    check("mid-period reset period_start", int'(period_start), 0);
    rst = 1'b0;
    cnt_a = 0;
    repeat (300) begin
      @(negedge clk);
      cnt_a += int'(period_start) + int'(pwm_out);
    end
    check("idle after reset", cnt_a, 0);
    ena = 1'b1;
    run_period(-1, '0, hi);
    check("reset duty restored", hi, 128);
    ena = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sin_pwm_modulator.md
SIN_PWM_MODULATOR -- requirements
Module: sin_pwm_modulator

Interface
REQ-001 SHALL have parameter CNT_W, default 8, PWM counter width; period = 2**CNT_W clk cycles.
REQ-002 SHALL have parameter DEADTIME, default 4, dead-time in clk cycles; used only under SIN_PWM_DEADTIME_EN.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ena  input  1  run request; high = modulate, low = finish period then idle.
REQ-006 SHALL have port SinValue_in  input  signed 31  sine sample from the upstream generator.
REQ-007 SHALL have port sample_valid  input  1  SinValue_in valid this cycle.
REQ-008 SHALL have port sample_ready  output  1  pending buffer empty; sample accepted when valid and ready.
REQ-009 SHALL have port pwm_out  output  1  registered PWM output.
REQ-010 SHALL have port period_start  output  1  one-cycle pulse on the first cycle of each period.
REQ-011 SHALL have port overflow  output  1  sticky flag: valid seen while not ready.

Function
REQ-012 SHALL convert a sample to duty = SinValue_in[30:31-CNT_W] with bit 30 inverted (offset binary): -2**30 -> 0, 0 -> 2**(CNT_W-1), max -> 2**CNT_W-1.
REQ-013 SHALL store an accepted duty in a pending register and set pending_valid.
REQ-014 SHALL drive sample_ready = !pending_valid.
REQ-015 SHALL, at counter wrap (cnt = 2**CNT_W-1), load active duty from pending and clear pending_valid; with no pending, active duty is held.
REQ-016 SHALL accept a new sample in the wrap cycle (pending load and accept same cycle: new sample stays pending).
REQ-017 SHALL implement FSM IDLE, RUN, DRAIN: IDLE->RUN when ena=1 (cnt starts at 0 next cycle); RUN->DRAIN when ena=0; DRAIN->IDLE at wrap; DRAIN->RUN if ena returns before wrap.
REQ-018 SHALL hold cnt at 0 and pwm_out at 0 in IDLE; cnt increments modulo 2**CNT_W in RUN and DRAIN.
REQ-019 SHALL register pwm_out = (cnt < active duty), one clk latency from cnt; duty 0 gives constant low, 2**CNT_W-1 gives high for 2**CNT_W-1 of 2**CNT_W cycles.
REQ-020 SHALL pulse period_start when cnt = 0 in RUN or DRAIN, aligned with the corresponding pwm_out cycle.
REQ-021 SHALL set overflow when sample_valid=1 and sample_ready=0; cleared only by rst.
REQ-022 SHALL accept samples in every state, including IDLE.

Reset
REQ-023 SHALL, on rst=1, force state IDLE, cnt 0, active duty 2**(CNT_W-1), pending_valid 0, pwm_out 0, period_start 0, overflow 0, sample_ready 1 next cycle.
REQ-024 SHALL let rst take priority over ena and sample_valid, including mid-period.

Configuration
REQ-025 SHALL, with SIN_PWM_DEADTIME_EN defined, add output pwm_n_out (1 bit): complement of pwm_out with both low for DEADTIME cycles after every pwm edge; pwm_out rise is also delayed DEADTIME cycles; both 0 in reset and IDLE.
REQ-026 SHALL, without SIN_PWM_DEADTIME_EN, omit pwm_n_out and the dead-time logic; pwm_out timing per REQ-019.

Structure
REQ-027 SHALL place the FSM state type and default constants (CNT_W, DEADTIME) in shared package sin_pwm_pkg.
REQ-028 SHALL implement dead-time insertion in sub-module sin_pwm_deadtime, instantiated only under SIN_PWM_DEADTIME_EN.

Verification (CNT_W=8)
REQ-029 SHALL cover: sample 0 accepted, ena=1 -> second period pwm_out high 128 of 256 cycles; first period 128 (reset duty).
REQ-030 SHALL cover: samples -2**30 then 2**30-1, one per period -> periods show 0 and 255 high cycles.
REQ-031 SHALL cover: two valid samples in one period -> sample_ready 0 after first, overflow 1, second dropped, duty from first.
REQ-032 SHALL cover: ena dropped at cnt=100 -> period completes to cnt=255, then IDLE, pwm_out 0, no further period_start.
REQ-033 SHALL cover: rst pulsed at cnt=50 -> next cycle pwm_out 0, overflow 0, sample_ready 1, state IDLE.
REQ-034 SHALL cover under SIN_PWM_DEADTIME_EN: duty 128 -> pwm_out high 124 cycles, pwm_n_out high 124 cycles, 4-cycle both-low gaps at each edge.
